timer_counter: RTL and testbench
================================

// Module: timer_counter
// PURPOSE
//  Counting core of the bus timer, directly downstream of the timer register block.
//  On read_req it becomes bus master and fetches the reload value from memory at LOAD_ADDRESS.
//  It then counts that value down to zero and holds there until int_clear.
//  It returns NEXT_* state and values, which the register block uses for interrupt generation and status readback.
// PARAMETERS
//  PRESCALE_DIV  16  clocks per count tick (used only with TIMER_PRESCALE_EN); legal range 2..256
// PORTS
//  clk                 in   1  system clock, rising edge
//  reset               in   1  asynchronous, active-high reset
//  read_req            in   1  1-cycle pulse from register block: start load fetch
//  LOAD_ADDRESS        in   8  bus address holding the reload value
//  CNT_CON             in   1  1 = continuous (auto-reload after clear), 0 = one-shot
//  int_clear           in   1  1-cycle pulse: interrupt acknowledged
//  M_grant             in   1  arbiter grant for M_req
//  M_din               in   8  bus read data (slave registers data 1 cycle after address)
//  M_req               out  1  bus request
//  M_address           out  8  bus address
//  M_wr                out  1  always 0 (read-only master)
//  NEXT_master_state   out  3  combinational next value of master FSM register
//  NEXT_counter_state  out  2  combinational next value of counter FSM register
//  NEXT_LOAD_VALUE     out  8  combinational next value of LOAD_VALUE register
//  NEXT_COUNT_VALUE    out  8  combinational next value of COUNT_VALUE register
// BEHAVIOUR
//  Reset: master_state=000, counter_state=00, LOAD_VALUE=0, COUNT_VALUE=0, M_req=0, M_address=0, M_wr=0.
//  Reset mid-fetch or mid-count aborts immediately; no bus cycle is resumed.
//  Master FSM (3b):
//   M_IDLE 000: read_req -> M_REQ. read_req in any other master state is ignored.
//   M_REQ 001: M_req=1. Stay until M_grant=1 -> M_ADDR.
//   M_ADDR 010: M_req=1, M_address=LOAD_ADDRESS -> M_DATA.
//   M_DATA 011: M_req=1; LOAD_VALUE<=M_din -> M_DONE.
//   M_DONE 100: M_req=0; start pulse to counter -> M_IDLE.
//   M_address=0 outside M_ADDR/M_DATA.
//   Latency: read_req to LOAD_VALUE valid = 3 cycles plus grant wait.
//  Counter FSM (2b):
//   C_IDLE 00: master M_DONE -> C_LOAD.
//   C_LOAD 01: COUNT_VALUE<=LOAD_VALUE -> C_DOWN.
//   C_DOWN 10: per tick COUNT_VALUE-=1 while >0. Count holds at 0; never wraps to 8'hFF.
//   At 0 the FSM stays in C_DOWN, so the register block sees 10 with count 0 and asserts interrupt.
//   int_clear in C_DOWN with COUNT_VALUE==0: CNT_CON=1 -> C_LOAD (reuse LOAD_VALUE, no refetch);
//   CNT_CON=0 -> C_IDLE, COUNT_VALUE stays 0.
//   int_clear with COUNT_VALUE!=0 or outside C_DOWN: ignored.
//   2'b11 is illegal -> C_IDLE.
//  LOAD_VALUE==0: C_LOAD -> C_DOWN with count 0, so the interrupt condition occurs on the next cycle.
//  Master and counter run independently. A fetch does not disturb counting; the new LOAD_VALUE
//   takes effect at the next C_LOAD. M_DONE while the counter is not in C_IDLE is dropped.
//  NEXT_* outputs are purely combinational from current state and inputs. Registers load them each clk.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined:
//   tick = 1 clock in PRESCALE_DIV, from an internal 8b prescaler.
//   Prescaler clears on C_LOAD entry and runs only in C_DOWN.
//  Not defined: tick = every clock; PRESCALE_DIV unused.
// TESTING
//  1. reset high mid-count (COUNT_VALUE=5) -> all outputs 0 asynchronously; FSMs 000/00 after release.
//  2. read_req, LOAD_ADDRESS=8'h40, M_grant after 2 cycles, M_din=8'h03
//     -> M_address=8'h40 in M_ADDR; LOAD_VALUE=3; count 3,2,1,0; hold 10/0 until int_clear.
//  3. CNT_CON=1, int_clear at count 0 -> C_LOAD, count reloads 3 without bus request.
//     CNT_CON=0 -> C_IDLE, count stays 0.
//  4. M_din=8'h00 -> C_DOWN with COUNT_VALUE=0 one cycle after C_LOAD; no underflow to 8'hFF.
//  5. Second read_req during M_REQ/M_DATA -> ignored, single bus transaction.
//     int_clear at count 2 -> ignored.
//  6. TIMER_PRESCALE_EN, PRESCALE_DIV=4, LOAD=2 -> decrements exactly 4 clocks apart.

Source files
------------

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - bus timer counting core: fetches a reload value over the bus, then counts it down to zero
// Optional build macro TIMER_PRESCALE_EN: count tick once every PRESCALE_DIV clocks instead of every clock.
module timer_counter #(
  parameter int PRESCALE_DIV = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       read_req,
  input  logic [7:0] LOAD_ADDRESS,
  input  logic       CNT_CON,
  input  logic       int_clear,
  input  logic       M_grant,
  input  logic [7:0] M_din,
  output logic       M_req,
  output logic [7:0] M_address,
  output logic       M_wr,
  output logic [2:0] NEXT_master_state,
  output logic [1:0] NEXT_counter_state,
  output logic [7:0] NEXT_LOAD_VALUE,
  output logic [7:0] NEXT_COUNT_VALUE
);

  typedef enum logic [2:0] {
    M_IDLE = 3'b000,
    M_REQ  = 3'b001,
    M_ADDR = 3'b010,
    M_DATA = 3'b011,
    M_DONE = 3'b100
  } master_t;

  typedef enum logic [1:0] {
    C_IDLE = 2'b00,
    C_LOAD = 2'b01,
    C_DOWN = 2'b10
  } counter_t;

  if (PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_prescale
    $error("PRESCALE_DIV must be in 2..256");
  end

  master_t    master_state, master_next;
  counter_t   counter_state, counter_next;
  logic [7:0] load_value, load_next;
  logic [7:0] count_value, count_next;
  logic       tick;

`ifdef TIMER_PRESCALE_EN
  localparam logic [7:0] PRESCALE_LAST = 8'(PRESCALE_DIV - 1);
  logic [7:0] prescale;

  assign tick = (prescale == PRESCALE_LAST);

  // Held at zero outside C_DOWN, so every count run starts a fresh prescale period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescale <= 8'd0;
    end else if (counter_state != C_DOWN || tick) begin
      prescale <= 8'd0;
    end else begin
      prescale <= prescale + 8'd1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  always_comb begin
    master_next = master_state;
    case (master_state)
      M_IDLE:  if (read_req) master_next = M_REQ;
      M_REQ:   if (M_grant) master_next = M_ADDR;
      M_ADDR:  master_next = M_DATA;
      M_DATA:  master_next = M_DONE;
      M_DONE:  master_next = M_IDLE;
      default: master_next = M_IDLE;
    endcase
  end

  // The slave returns data the cycle after the address phase, i.e. while in M_DATA.
  assign load_next = (master_state == M_DATA) ? M_din : load_value;

  always_comb begin
    counter_next = counter_state;
    count_next   = count_value;
    case (counter_state)
      C_IDLE: begin
        if (master_state == M_DONE) counter_next = C_LOAD;
      end
      C_LOAD: begin
        count_next   = load_value;
        counter_next = C_DOWN;
      end
      C_DOWN: begin
        if (count_value != 8'd0) begin
          if (tick) count_next = count_value - 8'd1;
        end else if (int_clear) begin
          counter_next = CNT_CON ? C_LOAD : C_IDLE;
        end
      end
      default: counter_next = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      master_state  <= M_IDLE;
      counter_state <= C_IDLE;
      load_value    <= 8'd0;
      count_value   <= 8'd0;
      M_req         <= 1'b0;
      M_address     <= 8'd0;
    end else begin
      master_state  <= master_next;
      counter_state <= counter_next;
      load_value    <= load_next;
      count_value   <= count_next;
      M_req         <= master_next inside {M_REQ, M_ADDR, M_DATA};
      // Address is captured on entry to M_ADDR and held through M_DATA.
      if (master_next == M_ADDR) begin
        M_address <= LOAD_ADDRESS;
      end else if (master_next != M_DATA) begin
        M_address <= 8'd0;
      end
    end
  end

  assign M_wr               = 1'b0;
  assign NEXT_master_state  = reset ? 3'b000 : master_next;
  assign NEXT_counter_state = reset ? 2'b00  : counter_next;
  assign NEXT_LOAD_VALUE    = reset ? 8'd0   : load_next;
  assign NEXT_COUNT_VALUE   = reset ? 8'd0   : count_next;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - randomized scoreboard bench for timer_counter
module tb_timer_counter;

`ifdef TIMER_PRESCALE_EN
  localparam int DIV = 16;
`else
  localparam int DIV = 1;
`endif

  logic       clk = 1'b0;
  logic       reset, read_req, CNT_CON, int_clear, M_grant;
  logic [7:0] LOAD_ADDRESS, M_din;
  logic       M_req, M_wr;
  logic [7:0] M_address;
  logic [2:0] nm;
  logic [1:0] nc;
  logic [7:0] nl, ncnt;

  timer_counter dut (
    .clk(clk), .reset(reset), .read_req(read_req), .LOAD_ADDRESS(LOAD_ADDRESS),
    .CNT_CON(CNT_CON), .int_clear(int_clear), .M_grant(M_grant), .M_din(M_din),
    .M_req(M_req), .M_address(M_address), .M_wr(M_wr),
    .NEXT_master_state(nm), .NEXT_counter_state(nc),
    .NEXT_LOAD_VALUE(nl), .NEXT_COUNT_VALUE(ncnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         t;
    logic       mreq;
    logic [7:0] maddr;
    logic [2:0] nm;
    logic [1:0] nc;
    logic [7:0] nl;
    logic [7:0] ncnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [256];
  int         tests = 0;
  int         fails = 0;

  // Scenario timeline (cycle indices relative to the read_req cycle)
  int         sa, sc1, sc2;
  bit         scon;
  logic [7:0] sd, sprev;

  task automatic check(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Bus slave: data for the presented address appears shortly after each clock edge.
  initial forever begin
    @(posedge clk);
    #2;
    M_din = mem[M_address];
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("M_req", e.t, {7'd0, M_req}, {7'd0, e.mreq});
      check("M_address", e.t, M_address, e.maddr);
      check("M_wr", e.t, {7'd0, M_wr}, 8'd0);
      check("NEXT_master_state", e.t, {5'd0, nm}, {5'd0, e.nm});
      check("NEXT_counter_state", e.t, {6'd0, nc}, {6'd0, e.nc});
      check("NEXT_LOAD_VALUE", e.t, nl, e.nl);
      check("NEXT_COUNT_VALUE", e.t, ncnt, e.ncnt);
    end
  end

  function automatic logic [2:0] exp_master(input int n);
    if (n >= 1 && n < sa) return 3'd1;
    if (n == sa)          return 3'd2;
    if (n == sa + 1)      return 3'd3;
    if (n == sa + 2)      return 3'd4;
    return 3'd0;
  endfunction

  function automatic logic [7:0] down(input int j);
    int v;
    v = int'(sd) - j / DIV;
    return (v > 0) ? 8'(v) : 8'd0;
  endfunction

  function automatic void exp_counter(input int n, output logic [1:0] st, output logic [7:0] cnt);
    st  = 2'd0;
    cnt = 8'd0;
    if (n == sa + 3) begin
      st = 2'd1;
    end else if (n >= sa + 4 && n <= sc1) begin
      st  = 2'd2;
      cnt = down(n - (sa + 4));
    end else if (scon && n == sc1 + 1) begin
      st = 2'd1;
    end else if (scon && n >= sc1 + 2 && n <= sc2) begin
      st  = 2'd2;
      cnt = down(n - (sc1 + 2));
    end
  endfunction

  // One fetch + count run starting and ending with both FSMs idle.
  task automatic run_scenario(input logic [7:0] addr, input logic [7:0] data, input int g,
                              input bit con, input bit noisy);
    int   last;
    exp_t e;
    sa   = 2 + g;
    sd   = data;
    scon = con;
    mem[addr] = data;
    sc1  = sa + 4 + int'(data) * DIV + int'($urandom_range(0, 3));
    sc2  = sc1 + 2 + int'(data) * DIV + int'($urandom_range(0, 3));
    last = (con ? sc2 : sc1) + 2;
    for (int t = 0; t <= last; t++) begin
      @(posedge clk);
      #1;
      LOAD_ADDRESS = addr;
      read_req  = (t == 0) || (noisy && t >= 1 && t <= sa + 2 && $urandom_range(0, 1) == 1);
      M_grant   = (t >= 1 + g && t <= sa + 1) || ((t == 0 || t > sa + 1) && $urandom_range(0, 1) == 1);
      int_clear = (t == sc1) || (con && t == sc2) ||
                  (noisy && (t == 1 || (t == sa + 4 && data != 8'd0)));
      CNT_CON   = (t == sc1) ? con : (t == sc2) ? 1'b0 : 1'($urandom_range(0, 1));
      e.t     = t;
      e.mreq  = (t >= 1 && t <= sa + 1);
      e.maddr = (t == sa || t == sa + 1) ? addr : 8'h00;
      e.nm    = exp_master(t + 1);
      exp_counter(t + 1, e.nc, e.ncnt);
      e.nl    = (t + 1 >= sa + 2) ? data : sprev;
      exp_q.push_back(e);
    end
    sprev = data;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit hit;
    reset = 1'b1; read_req = 1'b0; CNT_CON = 1'b0; int_clear = 1'b0;
    M_grant = 1'b0; LOAD_ADDRESS = 8'd0; M_din = 8'd0; sprev = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    @(negedge clk);
    @(negedge clk);
    check("reset M_req", 0, {7'd0, M_req}, 8'd0);
    check("reset M_address", 0, M_address, 8'd0);
    check("reset M_wr", 0, {7'd0, M_wr}, 8'd0);
    check("reset NEXT_master_state", 0, {5'd0, nm}, 8'd0);
    check("reset NEXT_counter_state", 0, {6'd0, nc}, 8'd0);
    check("reset NEXT_LOAD_VALUE", 0, nl, 8'd0);
    check("reset NEXT_COUNT_VALUE", 0, ncnt, 8'd0);
    reset = 1'b0;

    run_scenario(8'h40, 8'h03, 2, 1'b0, 1'b0);
    run_scenario(8'h40, 8'h03, 0, 1'b1, 1'b0);
    run_scenario(8'h17, 8'h00, 1, 1'b0, 1'b1);
    run_scenario(8'h9c, 8'h00, 3, 1'b1, 1'b0);
    run_scenario(8'h55, 8'h05, 2, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) begin
      run_scenario(8'($urandom), 8'($urandom_range(0, 12)), int'($urandom_range(0, 4)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    // Asynchronous reset in the middle of a count run at COUNT_VALUE=5.
    mem[8'h21] = 8'd9;
    @(posedge clk);
    #1;
    LOAD_ADDRESS = 8'h21; read_req = 1'b1; M_grant = 1'b1; int_clear = 1'b0; CNT_CON = 1'b0;
    @(posedge clk);
    #1;
    read_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      if (nc == 2'd2 && ncnt == 8'd5) hit = 1'b1;
    end
    check("reach count 5 before timeout", 0, {7'd0, hit}, 8'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async reset M_req", 1, {7'd0, M_req}, 8'd0);
    check("async reset M_address", 1, M_address, 8'd0);
    check("async reset NEXT_master_state", 1, {5'd0, nm}, 8'd0);
    check("async reset NEXT_counter_state", 1, {6'd0, nc}, 8'd0);
    check("async reset NEXT_LOAD_VALUE", 1, nl, 8'd0);
    check("async reset NEXT_COUNT_VALUE", 1, ncnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset NEXT_master_state", 2, {5'd0, nm}, 8'd0);
    check("post-reset NEXT_counter_state", 2, {6'd0, nc}, 8'd0);
    check("post-reset NEXT_COUNT_VALUE", 2, ncnt, 8'd0);
    check("post-reset M_req", 2, {7'd0, M_req}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
